// File: rtl/mc_ctrl_pkg.sv
// Shared state encoding, mux-select encodings and Moore output decode
// for the multicycle ARM main control FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXECUTER = 4'd2,
        S_EXECUTEI = 4'd3,
        S_ALUWB    = 4'd4,
        S_MEMADR   = 4'd5,
        S_MEMRD    = 4'd6,
        S_MEMWR    = 4'd7,
        S_MEMWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_EXUSTART = 4'd10,
        S_EXUWAIT  = 4'd11,
        S_WBLO     = 4'd12,
        S_WBHI     = 4'd13,
        S_RECOVER  = 4'd14
    } CtrlState;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BRANCH  = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam logic [1:0] RES_ALU       = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALUDIRECT = 2'b10;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // fetch and memWrite are qualifiers: the real strobes also need the memory to complete.
    typedef struct packed {
        logic       fetch;
        logic       memWrite;
        logic       regW;
        logic       branch;
        logic       aluOp;
        logic       adrSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] resultSrc;
        logic       exuStart;
        logic       wbHi;
    } MooreOut;

    function automatic MooreOut decodeOutputs(input CtrlState s);
        MooreOut o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.fetch     = 1'b1;
                o.aluSrcA   = SRCA_PC;
                o.aluSrcB   = SRCB_FOUR;
                o.resultSrc = RES_ALUDIRECT;
            end
            S_DECODE: begin
                o.aluSrcA   = SRCA_PC;
                o.aluSrcB   = SRCB_FOUR;
                o.resultSrc = RES_ALUDIRECT;
            end
            S_EXECUTER: begin
                o.aluSrcA = SRCA_REG;
                o.aluSrcB = SRCB_REG;
                o.aluOp   = 1'b1;
            end
            S_EXECUTEI: begin
                o.aluSrcB = SRCB_IMM;
                o.aluOp   = 1'b1;
            end
            S_ALUWB: begin
                o.resultSrc = RES_ALU;
                o.regW      = 1'b1;
            end
            S_MEMADR: o.aluSrcB = SRCB_IMM;
            S_MEMRD:  o.adrSrc  = 1'b1;
            S_MEMWR: begin
                o.adrSrc   = 1'b1;
                o.memWrite = 1'b1;
            end
            S_MEMWB: begin
                o.resultSrc = RES_DATA;
                o.regW      = 1'b1;
            end
            S_BRANCH: begin
                o.aluSrcB   = SRCB_IMM;
                o.resultSrc = RES_ALUDIRECT;
                o.branch    = 1'b1;
            end
            S_EXUSTART: o.exuStart = 1'b1;
            S_WBLO: begin
                o.regW      = 1'b1;
                o.resultSrc = RES_ALU;
            end
            S_WBHI: begin
                o.regW      = 1'b1;
                o.resultSrc = RES_ALU;
                o.wbHi      = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Decoder/datapath-facing bundle of the main control FSM: instruction class
// and handshake inputs in, datapath enables and mux selects out.
interface mc_ctrl_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       ExuOp;
    logic       Long64;
    logic       MemReady;
    logic       ExuDone;

    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ExuStart;
    logic       WbHi;
    logic       ExuErr;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        output Op, Funct, ExuOp, Long64, MemReady, ExuDone,
        input  IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ExuStart, WbHi, ExuErr, IllegalOp, State
    );

    modport slave (
        input  Op, Funct, ExuOp, Long64, MemReady, ExuDone,
        output IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ExuStart, WbHi, ExuErr, IllegalOp, State
    );
endinterface

// File: rtl/mc_ctrl_exu_timer.sv
// Counts EXUWAIT cycles without ExuDone and flags the cycle in which the
// execution unit has used up its allowed wait.
module exu_timer #(
    parameter int EXU_TIMEOUT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);
    localparam int CW = $clog2(EXU_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(EXU_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign timeout = enable && (r_count == LAST);
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle ARM core: fetch/decode/execute/memory/
// writeback with memory wait states, a timed EXU handshake and 64-bit writeback.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT    = 0,
    parameter int EXU_EN      = 1,
    parameter int EXU_TIMEOUT = 32
) (
    input logic      clk,
    input logic      reset,
    mc_ctrl_if.slave bus
);
    CtrlState r_state;
    CtrlState w_nextState;
    MooreOut  r_out;
    logic     r_long64;
    logic     w_memDone;
    logic     w_live;
    logic     w_timerEn;
    logic     w_timerClr;
    logic     w_timeout;
    logic     w_isDecode;
    logic     w_unusedFunct;

    assign w_live        = ~reset;
    assign w_memDone     = (MEM_WAIT == 0) ? 1'b1 : bus.MemReady;
    assign w_isDecode    = (r_state == S_DECODE);
    assign w_timerClr    = (r_state == S_EXUSTART);
    assign w_timerEn     = (r_state == S_EXUWAIT) && !bus.ExuDone;
    assign w_unusedFunct = ^bus.Funct[4:1];

    exu_timer #(
        .EXU_TIMEOUT(EXU_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_timerClr),
        .enable (w_timerEn),
        .timeout(w_timeout)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_FETCH:  if (w_memDone) w_nextState = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_DP: begin
                        if (bus.ExuOp && (EXU_EN != 0)) w_nextState = S_EXUSTART;
                        else if (bus.Funct[5])          w_nextState = S_EXECUTEI;
                        else                            w_nextState = S_EXECUTER;
                    end
                    OP_MEM:    w_nextState = S_MEMADR;
                    OP_BRANCH: w_nextState = S_BRANCH;
                    default:   w_nextState = S_FETCH;
                endcase
            end
            S_EXECUTER, S_EXECUTEI: w_nextState = S_ALUWB;
            S_MEMADR:   w_nextState = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (w_memDone) w_nextState = S_MEMWB;
            S_MEMWR:    if (w_memDone) w_nextState = S_FETCH;
            S_EXUSTART: w_nextState = S_EXUWAIT;
            S_EXUWAIT: begin
                if (bus.ExuDone)    w_nextState = S_WBLO;
                else if (w_timeout) w_nextState = S_FETCH;
            end
            S_WBLO:  w_nextState = r_long64 ? S_WBHI : S_FETCH;
            default: w_nextState = S_FETCH;
        endcase
    end

    // Moore outputs are decoded from the next state so they appear registered
    // in the same cycle the state does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_out    <= decodeOutputs(S_FETCH);
            r_long64 <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_out   <= decodeOutputs(w_nextState);
            if (r_state == S_DECODE) begin
                r_long64 <= bus.Long64;
            end
        end
    end

    assign bus.IRWrite   = w_live & r_out.fetch & w_memDone;
    assign bus.NextPC    = w_live & r_out.fetch & w_memDone;
    assign bus.MemW      = w_live & r_out.memWrite & w_memDone;
    assign bus.RegW      = w_live & r_out.regW;
    assign bus.Branch    = w_live & r_out.branch;
    assign bus.ALUOp     = w_live & r_out.aluOp;
    assign bus.AdrSrc    = w_live & r_out.adrSrc;
    assign bus.ALUSrcA   = w_live ? r_out.aluSrcA : 2'b00;
    assign bus.ALUSrcB   = w_live ? r_out.aluSrcB : 2'b00;
    assign bus.ResultSrc = w_live ? r_out.resultSrc : 2'b00;
    assign bus.ExuStart  = w_live & r_out.exuStart;
    assign bus.WbHi      = w_live & r_out.wbHi;
    assign bus.ExuErr    = w_live & w_timeout;
    assign bus.IllegalOp = w_live & w_isDecode & (bus.Op == OP_ILLEGAL);
    assign bus.State     = r_state;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed instruction table with latency
// checks, randomized instructions against a phase-list model, and reset corners.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    localparam int T = 4;

    typedef struct packed {
        logic       irw, npc, regw, memw, br, aluop, adr;
        logic [1:0] sa, sb, rs;
        logic       xs, wbhi, err, ill;
    } Outs;

    typedef struct packed {
        logic       mr, ed, l64, xop;
        logic [3:0] st;
        Outs        o;
    } Entry;

    typedef struct packed {
        logic [1:0] op;
        logic [5:0] funct;
        logic       xop, l64;
        int         fw, mw, exuN;
    } Instr;

    typedef struct packed {
        Instr ins;
        int   expLat;
    } Vec;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    Entry expQ[$];
    logic [3:0] obsQ[$];
    Vec   vecs[10];

    mc_ctrl_if busIf();

    mc_ctrl_fsm #(.MEM_WAIT(1), .EXU_EN(1), .EXU_TIMEOUT(T)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (busIf)
    );

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic Instr mkInstr(logic [1:0] op, logic [5:0] funct, logic xop, logic l64,
                                     int fw, int mw, int exuN);
        Instr d;
        d.op = op; d.funct = funct; d.xop = xop; d.l64 = l64;
        d.fw = fw; d.mw = mw; d.exuN = exuN;
        return d;
    endfunction

    // Per-state output table straight from the state descriptions; strobes added by the caller.
    function automatic Outs base(CtrlState st);
        Outs o;
        o = '0;
        case (st)
            S_FETCH, S_DECODE: begin o.sa = 2'b01; o.sb = 2'b10; o.rs = 2'b10; end
            S_EXECUTER: o.aluop = 1'b1;
            S_EXECUTEI: begin o.sb = 2'b01; o.aluop = 1'b1; end
            S_ALUWB:    o.regw = 1'b1;
            S_MEMADR:   o.sb = 2'b01;
            S_MEMRD, S_MEMWR: o.adr = 1'b1;
            S_MEMWB:    begin o.rs = 2'b01; o.regw = 1'b1; end
            S_BRANCH:   begin o.sb = 2'b01; o.rs = 2'b10; o.br = 1'b1; end
            S_EXUSTART: o.xs = 1'b1;
            S_WBLO:     o.regw = 1'b1;
            S_WBHI:     begin o.regw = 1'b1; o.wbhi = 1'b1; end
            default:    o = '0;
        endcase
        return o;
    endfunction

    function automatic Outs sampleOuts();
        Outs o;
        o.irw = busIf.IRWrite;  o.npc = busIf.NextPC; o.regw = busIf.RegW;
        o.memw = busIf.MemW;    o.br = busIf.Branch;  o.aluop = busIf.ALUOp;
        o.adr = busIf.AdrSrc;   o.sa = busIf.ALUSrcA; o.sb = busIf.ALUSrcB;
        o.rs = busIf.ResultSrc; o.xs = busIf.ExuStart; o.wbhi = busIf.WbHi;
        o.err = busIf.ExuErr;   o.ill = busIf.IllegalOp;
        return o;
    endfunction

    task automatic pushE(CtrlState st, Outs o, logic mr, logic ed, logic l64, logic xop);
        Entry e;
        e.mr = mr; e.ed = ed; e.l64 = l64; e.xop = xop; e.st = st; e.o = o;
        expQ.push_back(e);
    endtask

    // Reference model: the instruction expands into a list of phases, each phase a cycle.
    task automatic buildTrace(Instr d);
        Outs o;
        expQ.delete();
        for (int w = 0; w < d.fw; w++) pushE(S_FETCH, base(S_FETCH), 1'b0, rb(), d.l64, d.xop);
        o = base(S_FETCH); o.irw = 1'b1; o.npc = 1'b1;
        pushE(S_FETCH, o, 1'b1, rb(), d.l64, d.xop);
        o = base(S_DECODE); o.ill = (d.op == 2'b11);
        pushE(S_DECODE, o, rb(), rb(), d.l64, d.xop);
        if (d.op == 2'b00 && d.xop) begin
            pushE(S_EXUSTART, base(S_EXUSTART), rb(), rb(), rb(), rb());
            if (d.exuN >= 1 && d.exuN <= T) begin
                for (int k = 1; k <= d.exuN; k++)
                    pushE(S_EXUWAIT, base(S_EXUWAIT), rb(), (k == d.exuN), rb(), rb());
                pushE(S_WBLO, base(S_WBLO), rb(), rb(), rb(), rb());
                if (d.l64) pushE(S_WBHI, base(S_WBHI), rb(), rb(), rb(), rb());
            end else begin
                for (int k = 1; k <= T; k++) begin
                    o = base(S_EXUWAIT); o.err = (k == T);
                    pushE(S_EXUWAIT, o, rb(), 1'b0, rb(), rb());
                end
            end
        end else if (d.op == 2'b00) begin
            if (d.funct[5]) pushE(S_EXECUTEI, base(S_EXECUTEI), rb(), rb(), rb(), rb());
            else            pushE(S_EXECUTER, base(S_EXECUTER), rb(), rb(), rb(), rb());
            pushE(S_ALUWB, base(S_ALUWB), rb(), rb(), rb(), rb());
        end else if (d.op == 2'b01) begin
            pushE(S_MEMADR, base(S_MEMADR), rb(), rb(), rb(), rb());
            if (d.funct[0]) begin
                for (int w = 0; w < d.mw; w++) pushE(S_MEMRD, base(S_MEMRD), 1'b0, rb(), rb(), rb());
                pushE(S_MEMRD, base(S_MEMRD), 1'b1, rb(), rb(), rb());
                pushE(S_MEMWB, base(S_MEMWB), rb(), rb(), rb(), rb());
            end else begin
                for (int w = 0; w < d.mw; w++) pushE(S_MEMWR, base(S_MEMWR), 1'b0, rb(), rb(), rb());
                o = base(S_MEMWR); o.memw = 1'b1;
                pushE(S_MEMWR, o, 1'b1, rb(), rb(), rb());
            end
        end else if (d.op == 2'b10) begin
            pushE(S_BRANCH, base(S_BRANCH), rb(), rb(), rb(), rb());
        end
    endtask

    task automatic applyStimulus(Entry e);
        busIf.MemReady = e.mr;
        busIf.ExuDone  = e.ed;
        busIf.Long64   = e.l64;
        busIf.ExuOp    = e.xop;
    endtask

    task automatic checkOutput(Entry e, int idx, string tag);
        logic [20:0] got;
        @(negedge clk);
        got = {busIf.State, sampleOuts()};
        obsQ.push_back(busIf.State);
        total++;
        if (got !== {e.st, e.o}) begin
            bad++;
            $display("[TB] FAIL %s cycle %0d: got state=%0d outs=%h, want state=%0d outs=%h",
                     tag, idx, got[20:17], got[16:0], e.st, e.o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runInstr(Instr d, int expLat, string tag);
        int meas;
        busIf.Op    = d.op;
        busIf.Funct = d.funct;
        buildTrace(d);
        obsQ.delete();
        for (int i = 0; i < expQ.size(); i++) begin
            applyStimulus(expQ[i]);
            checkOutput(expQ[i], i, tag);
        end
        busIf.MemReady = 1'b0;
        busIf.ExuDone  = rb();
        @(negedge clk);
        obsQ.push_back(busIf.State);
        @(posedge clk);
        #1;
        if (expLat > 0) begin
            meas = -1;
            for (int i = 1; i < obsQ.size(); i++)
                if (meas < 0 && obsQ[i] == S_FETCH && obsQ[i-1] != S_FETCH) meas = i;
            total++;
            if (meas != expLat) begin
                bad++;
                $display("[TB] FAIL %s latency: got %0d, want %0d", tag, meas, expLat);
            end
        end
    endtask

    task automatic checkAllZero(string tag);
        logic [20:0] got;
        got = {busIf.State, sampleOuts()};
        total++;
        if (got !== 21'd0) begin
            bad++;
            $display("[TB] FAIL %s: got state=%0d outs=%h, want state=0 outs=0",
                     tag, got[20:17], got[16:0]);
        end
    endtask

    initial begin
        Instr d;
        vecs[0] = '{mkInstr(2'b00, 6'b001000, 1'b0, 1'b0, 0, 0, 0), 4};
        vecs[1] = '{mkInstr(2'b00, 6'b100000, 1'b0, 1'b0, 0, 0, 0), 4};
        vecs[2] = '{mkInstr(2'b01, 6'b000001, 1'b0, 1'b0, 3, 2, 0), 10};
        vecs[3] = '{mkInstr(2'b01, 6'b000000, 1'b0, 1'b0, 1, 1, 0), 6};
        vecs[4] = '{mkInstr(2'b10, 6'b000000, 1'b0, 1'b0, 0, 0, 0), 3};
        vecs[5] = '{mkInstr(2'b00, 6'b000000, 1'b1, 1'b1, 0, 0, 4), 9};
        vecs[6] = '{mkInstr(2'b00, 6'b100000, 1'b1, 1'b0, 0, 0, 1), 5};
        vecs[7] = '{mkInstr(2'b00, 6'b000000, 1'b1, 1'b1, 0, 0, 0), 7};
        vecs[8] = '{mkInstr(2'b11, 6'b000000, 1'b0, 1'b0, 0, 0, 0), 2};
        vecs[9] = '{mkInstr(2'b00, 6'b000000, 1'b1, 1'b1, 2, 0, 2), 9};

        busIf.Op = 2'b11; busIf.Funct = 6'h3f; busIf.ExuOp = 1'b1;
        busIf.Long64 = 1'b1; busIf.MemReady = 1'b1; busIf.ExuDone = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset_idle");
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) runInstr(vecs[i].ins, vecs[i].expLat, $sformatf("vec%0d", i));

        for (int n = 0; n < 80; n++) begin
            d = mkInstr(2'($urandom_range(0, 3)), 6'($urandom), rb(), rb(),
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, T));
            runInstr(d, -1, $sformatf("rnd%0d", n));
        end

        // Reset in the middle of EXUWAIT must abandon the instruction with no writeback.
        d = mkInstr(2'b00, 6'b000000, 1'b1, 1'b1, 0, 0, 0);
        busIf.Op = d.op;
        busIf.Funct = d.funct;
        buildTrace(d);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(expQ[i]);
            checkOutput(expQ[i], i, "exu_pre_reset");
        end
        busIf.MemReady = 1'b1;
        busIf.ExuDone  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("reset_in_exuwait");
        busIf.ExuDone = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("reset_held_edge");
        reset = 1'b0;
        runInstr(mkInstr(2'b00, 6'b001000, 1'b0, 1'b0, 0, 0, 0), 4, "dp_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Parametrised main control FSM for the multicycle ARM core; next generation of the fixed-latency main FSM inside the instruction decoder. It sequences fetch/decode/execute/memory/writeback. It adds three behaviours: an optional memory wait-state handshake, a start/done handshake to a variable-latency execution unit (MUL/UMULL/SMULL/FPU) with a timeout, and two-beat 64-bit register writeback. It sits between the instruction decoder (Op/Funct/class inputs) and the datapath/condition logic (enables and mux selects).

## Interface
- MEM_WAIT, default 0: 1 = FETCH/MEMRD/MEMWR hold until MemReady; 0 = MemReady ignored.
- EXU_EN, default 1: 1 = ExuOp instructions use the EXU handshake; 0 = ExuOp ignored, treated as plain data-processing.
- EXU_TIMEOUT, default 32: maximum EXUWAIT cycles before abort (≥1).
- clk  in  1  core clock; one clock domain.
- reset  in  1  asynchronous, active-high.
- Op  in  2  instruction class (00 DP, 01 mem, 10 branch, 11 illegal).
- Funct  in  6  Funct[5] = immediate, Funct[0] = L (load) for mem.
- ExuOp  in  1  decoder marks variable-latency op.
- Long64  in  1  decoder marks 64-bit result (UMULL/SMULL).
- MemReady  in  1  memory completes access this cycle.
- ExuDone  in  1  EXU result valid this cycle.
- IRWrite, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  standard multicycle enables.
- AdrSrc  out  1  0 = PC, 1 = ALU result.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects.
- ExuStart  out  1  one-cycle EXU launch pulse.
- WbHi  out  1  selects high result word for writeback.
- ExuErr, IllegalOp  out  1 each  one-cycle error pulses.
- State  out  4  current state, for debug.

## Operation
- While reset is high: all outputs 0, State = FETCH. FETCH is evaluated on the first clock edge after reset deasserts.
- Moore outputs; any output not listed for a state is 0.
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10. IRWrite and NextPC are asserted only in the completing cycle (MemReady=1, or always if MEM_WAIT=0).
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1; MemW=1 in the completing cycle only.
  - MEMWB: ResultSrc=01, RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
  - EXUSTART: ExuStart=1.
  - EXUWAIT: no outputs.
  - WBLO: RegW=1, ResultSrc=00.
  - WBHI: RegW=1, ResultSrc=00, WbHi=1.
- Transitions:
  - FETCH→DECODE on completion; otherwise stay.
  - DECODE:
    - Op=00 & ExuOp & EXU_EN → EXUSTART.
    - Op=00 & Funct[5] → EXECUTEI.
    - Op=00 otherwise → EXECUTER.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=11 → FETCH, with IllegalOp pulsed in the DECODE cycle.
  - EXECUTER/EXECUTEI → ALUWB → FETCH.
  - MEMADR → MEMRD if Funct[0], else MEMWR.
  - MEMRD → MEMWB on completion → FETCH.
  - MEMWR → FETCH on completion.
  - BRANCH → FETCH.
  - EXUSTART → EXUWAIT.
  - EXUWAIT:
    - ExuDone → WBLO.
    - Timeout → FETCH, with ExuErr pulsed and no writeback.
  - WBLO → WBHI if Long64 (sampled at DECODE and held), else → FETCH.
  - WBHI → FETCH.

## Timing
- Latency with MEM_WAIT=0:
  - DP: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - EXU op: 4 + N cycles, + 1 if Long64 (N = EXUWAIT cycles including the ExuDone cycle).
- Each memory wait cycle adds 1 cycle.
- Timeout counter:
  - Width $clog2(EXU_TIMEOUT+1). Cleared on entering EXUWAIT; increments each EXUWAIT cycle with ExuDone=0.
  - Timeout fires when count = EXU_TIMEOUT-1 and ExuDone=0.
  - ExuDone in that same cycle wins: normal writeback.
- ExuDone outside EXUWAIT is ignored. MemReady outside the memory states is ignored.
- Long64 and ExuOp are latched at DECODE; later input changes are ignored.
- Reset asserted mid-instruction (any state, including EXUWAIT): immediate return to FETCH with outputs 0. No partial writeback completes.

## Structure
- Shared package mc_ctrl_pkg:
  - State enum (15 states, 4 bits).
  - ResultSrc encodings: 00 ALU, 01 data, 10 ALU-direct.
  - ALUSrcA/ALUSrcB encodings.
  - Op class constants.
- Sub-module exu_timer (parameter EXU_TIMEOUT): inputs clear/enable, output timeout flag.

## Test plan
- Reset then DP register op (Op=00, Funct=001000), MEM_WAIT=0:
  - State sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH.
  - RegW high exactly 1 cycle; IRWrite high 1 cycle.
- Load with MEM_WAIT=1, MemReady low 3 cycles in FETCH and 2 cycles in MEMRD:
  - 10 cycles total.
  - IRWrite/NextPC asserted only in the MemReady cycle.
- UMULL (ExuOp=1, Long64=1), ExuDone after 5 EXUWAIT cycles:
  - ExuStart pulses once.
  - WBLO then WBHI; WbHi high only in WBHI.
- EXU_TIMEOUT=4, ExuDone never asserted:
  - ExuErr pulses in the 4th EXUWAIT cycle; next state FETCH; RegW never high.
  - Repeat with ExuDone arriving in that same 4th cycle → writeback, no ExuErr.
- Op=11 → IllegalOp pulse in DECODE, then FETCH.
  - Separately: reset asserted during EXUWAIT → all outputs 0 immediately; FETCH after deassert.
